// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants and helpers for the 7-segment scan driver.
//   SEG_TABLE     : hex digit -> {g,f,e,d,c,b,a}, active-high
//   inactive_lvl  : idle pin level for a given display polarity
//   clog2         : bit width needed to count 0..v-1 (minimum 1)
package seg7_pkg;

  // Entry 0 sits in the least significant slice, so SEG_TABLE[h] is digit h.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Common-anode boards sink current, so their idle level is high.
  function automatic logic inactive_lvl(input int common_anode);
    return (common_anode != 0) ? 1'b1 : 1'b0;
  endfunction

  // Never returns 0, so a counter that only ever holds 0 still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((32'(1) << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: datapath-side control bundle of the scan driver.
//   value_in   : packed hex digits, digit 0 in [3:0] (rightmost)
//   dp_in      : decimal-point request per digit
//   load       : one-cycle strobe, captures value_in/dp_in into the shadow
//   blank_lz   : leading-zero blanking enable
//   blink_mask : digits that blink
//   enable     : display enable; low blanks every output pin
// master = datapath that drives the bundle, slave = the scan driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    enable;

  modport master (
    output value_in, dp_in, load, blank_lz, blink_mask, enable
  );

  modport slave (
    input value_in, dp_in, load, blank_lz, blink_mask, enable
  );
endinterface

// File: rtl/seg7_scan_driver_hex_lut.sv
// seg7_hex_lut: combinational hex-to-segment decoder.
//   hex : 4-bit digit
//   seg : {g,f,e,d,c,b,a}, active-high (polarity is applied by the caller)
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment display driver.
//   clk, rst_n  : single clock, asynchronous active-low reset
//   ctrl        : datapath bundle (value, dp, load, blank/blink, enable)
//   segments    : {g,f,e,d,c,b,a} of the digit being scanned
//   dp_out      : decimal point of the digit being scanned
//   digit_sel   : one-hot digit enable
//   frame_tick  : one-cycle pulse on the last slot of every scan frame
// COMMON_ANODE inverts segments, dp_out and digit_sel (frame_tick is never
// inverted). The displayed value is double-buffered: load writes the shadow,
// the active copy is only refreshed on the frame boundary, so a frame never
// mixes digits of two different values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int COMMON_ANODE = 0,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     ctrl,
  output logic [6:0]            segments,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam int PRESC_W = clog2(SCAN_DIV);
  localparam int IDX_W   = clog2(NUM_DIGITS);
  localparam int BLINK_W = clog2(BLINK_FRAMES);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(SCAN_DIV - 2);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic INACT = inactive_lvl(COMMON_ANODE);

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc;
  logic [IDX_W-1:0]   idx;
  logic               slot_adv;
  logic               frame_pre;

  assign slot_adv  = (presc == PRESC_LAST);
  // Decoded one cycle early so frame_tick can be a flop yet still coincide
  // with the slot_adv that wraps the digit index.
  assign frame_pre = (presc == PRESC_PRE) && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= slot_adv ? '0 : presc + PRESC_W'(1);
      frame_tick <= frame_pre;
      if (slot_adv)
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active buffers
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]      shadow_dp,  active_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
    end else begin
      if (ctrl.load) begin
        shadow_val <= ctrl.value_in;
        shadow_dp  <= ctrl.dp_in;
      end
      // A load on the boundary cycle bypasses the shadow so it shows at once.
      if (frame_tick) begin
        active_val <= ctrl.load ? ctrl.value_in : shadow_val;
        active_dp  <= ctrl.load ? ctrl.dp_in    : shadow_dp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase: toggles every BLINK_FRAMES frames
  // ---------------------------------------------------------------------------
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection, walked down from the most significant digit.
  // A set dp stops the run, so "0.5" keeps its leading zero.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;

  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run & (active_val[k] == 4'd0) & ~active_dp[k];
      lz_blank[k] = lz_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit segment decode
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][6:0] dig_seg;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    seg7_hex_lut u_lut (
      .hex (active_val[g]),
      .seg (dig_seg[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Output stage: one register between the scan state and the pins
  // ---------------------------------------------------------------------------
  logic                  dig_blank;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] sel_d;

  assign sel_onehot = NUM_DIGITS'(1) << idx;
  assign dig_blank  = (ctrl.blank_lz & lz_blank[idx])
                    | (blink_phase & ctrl.blink_mask[idx]);

  always_comb begin
    seg_d = {7{INACT}};
    dp_d  = INACT;
    sel_d = {NUM_DIGITS{INACT}};
    if (ctrl.enable) begin
      // A blanked digit still gets its enable so the scan duty cycle of the
      // remaining digits is unchanged.
      sel_d = sel_onehot ^ {NUM_DIGITS{INACT}};
      if (!dig_blank) begin
        seg_d = dig_seg[idx] ^ {7{INACT}};
        dp_d  = active_dp[idx] ^ INACT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments  <= {7{INACT}};
      dp_out    <= INACT;
      digit_sel <= {NUM_DIGITS{INACT}};
    end else begin
      segments  <= seg_d;
      dp_out    <= dp_d;
      digit_sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a common-cathode and a common-anode instance
// share one control bundle; every expected slot is queued when stimulus is
// applied and popped when the sampled slot comes around.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  logic [6:0]   seg_a, seg_b;
  logic         dp_a, dp_b, ft_a, ft_b;
  logic [N-1:0] sel_a, sel_b;

  seg7_scan_driver #(.NUM_DIGITS(N), .COMMON_ANODE(0), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) u_dut_cc (
    .clk(clk), .rst_n(rst_n), .ctrl(bus),
    .segments(seg_a), .dp_out(dp_a), .digit_sel(sel_a), .frame_tick(ft_a)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .COMMON_ANODE(1), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) u_dut_ca (
    .clk(clk), .rst_n(rst_n), .ctrl(bus),
    .segments(seg_b), .dp_out(dp_b), .digit_sel(sel_b), .frame_tick(ft_b)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_err    = 0;
  int   tick_cnt;

  // Frames seen since reset; the frame after tick n has blink phase (n/BF)%2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= 0;
    else if (ft_a) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0][6:0] seg, input logic [3:0] dpo);
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 0; d < N; d++) sb.push_back('{sel: one << d, seg: seg[d], dp: dpo[d]});
  endtask

  task automatic check_slot(input string nm);
    exp_t       e;
    logic [11:0] inv;
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e   = sb.pop_front();
    inv = ~e;
    check({nm, "_cc"}, {sel_a, seg_a, dp_a}, e);
    check({nm, "_ca"}, {sel_b, seg_b, dp_b}, inv);
  endtask

  task automatic wait_tick(output int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ft_a) got = 1'b1;
    end
    check("tick_seen", got, 1);
    if (got) check("tick_ca", ft_b, 1);
    n = tick_cnt + 1;
  endtask

  // Slot d of the frame following a tick is visible from tick+2+4d.
  task automatic sample_frame(input string nm, input int pre);
    repeat (pre) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check_slot($sformatf("%s_d%0d", nm, d));
      if (d < N - 1) repeat (SD) @(negedge clk);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    int n;
    bus.blank_lz = vecs[i].lz;
    pulse_load(vecs[i].value, vecs[i].dp);
    wait_tick(n);
    push_frame(vecs[i].seg, vecs[i].dpo);
    sample_frame($sformatf("vec%0d", i), 2);
  endtask

  initial begin
    int n;
    int gap;
    bit ph;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000};
    vecs[4] = '{16'h0050, 4'b0100, 1'b1, {7'h00, 7'h3F, 7'h6D, 7'h3F}, 4'b0100};
    vecs[5] = '{16'h89AB, 4'b0000, 1'b1, {7'h7F, 7'h6F, 7'h77, 7'h7C}, 4'b0000};
    vecs[6] = '{16'hCDEF, 4'b1010, 1'b0, {7'h39, 7'h5E, 7'h79, 7'h71}, 4'b1010};
    vecs[7] = '{16'h0567, 4'b1000, 1'b1, {7'h3F, 7'h6D, 7'h7D, 7'h07}, 4'b1000};

    bus.value_in   = '0;
    bus.dp_in      = '0;
    bus.load       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = '0;
    bus.enable     = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_cc", {sel_a, seg_a, dp_a, ft_a}, 13'h0000);
    check("reset_ca", {sel_b, seg_b, dp_b, ft_b}, 13'h1FFE);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 8; i++) apply_vec(i);

    // Two loads inside one frame: current frame untouched, only the last shows
    apply_vec(0);
    wait_tick(n);
    push_frame(vecs[0].seg, vecs[0].dpo);
    repeat (2) @(negedge clk);
    check_slot("tear_d0");
    pulse_load(16'hAAAA, 4'b0000);
    repeat (SD - 1) @(negedge clk);
    check_slot("tear_d1");
    pulse_load(16'hBBBB, 4'b0000);
    repeat (SD - 1) @(negedge clk);
    check_slot("tear_d2");
    repeat (SD) @(negedge clk);
    check_slot("tear_d3");
    wait_tick(n);
    push_frame({7'h7C, 7'h7C, 7'h7C, 7'h7C}, 4'b0000);
    sample_frame("tear_next", 2);

    // Load on the boundary cycle is displayed in the new frame
    wait_tick(n);
    bus.value_in = 16'hF00F;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b1;
    push_frame({7'h71, 7'h3F, 7'h3F, 7'h71}, 4'b0000);
    @(negedge clk);
    bus.load = 1'b0;
    sample_frame("load_on_tick", 1);

    // Disable: inactive from the next cycle, frame timing keeps running
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_cc", {sel_a, seg_a, dp_a}, 12'h000);
    check("dis_ca", {sel_b, seg_b, dp_b}, 12'hFFF);
    repeat (5) @(negedge clk);
    check("dis_hold_cc", {sel_a, seg_a, dp_a}, 12'h000);
    check("dis_hold_ca", {sel_b, seg_b, dp_b}, 12'hFFF);
    wait_tick(n);
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (ft_a) break;
    end
    check("tick_spacing", gap, SD * N);
    check("dis_tick_cc", {sel_a, seg_a, dp_a}, 12'h000);
    bus.enable = 1'b1;
    wait_tick(n);
    push_frame({7'h71, 7'h3F, 7'h3F, 7'h71}, 4'b0000);
    sample_frame("reenable", 2);

    // Blink on digit 0, BF frames off / BF frames on
    bus.blink_mask = 4'b0001;
    bus.blank_lz   = 1'b0;
    pulse_load(16'h1234, 4'b0001);
    for (int f = 0; f < 4; f++) begin
      wait_tick(n);
      ph = ((n / BF) % 2) != 0;
      push_frame({7'h06, 7'h5B, 7'h4F, ph ? 7'h00 : 7'h66}, {3'b000, !ph});
      sample_frame($sformatf("blink_f%0d", f), 2);
    end
    bus.blink_mask = '0;

    // Asynchronous reset mid-scan drops the pending shadow
    pulse_load(16'h5555, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cc", {sel_a, seg_a, dp_a, ft_a}, 13'h0000);
    check("midrst_ca", {sel_b, seg_b, dp_b, ft_b}, 13'h1FFE);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{sel: 4'b0001, seg: 7'h3F, dp: 1'b0});
    @(negedge clk);
    check_slot("post_rst");
    wait_tick(n);
    push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
    sample_frame("shadow_lost", 2);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
